// File: rtl/ex_stage_muldiv.sv
// RV32IM execute stage: ALU, branch/jump redirect, iterative mul/div unit,
// and the EX/MEM pipeline register.
module ex_stage_muldiv #(
  parameter int BIT_W      = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = BIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [BIT_W-1:0] pc_in,
  input  logic [BIT_W-1:0] rs1_dat_in,
  input  logic [BIT_W-1:0] rs2_dat_in,
  input  logic [BIT_W-1:0] imm,
  input  logic             fwd_a_flag,
  input  logic             fwd_b_flag,
  input  logic [BIT_W-1:0] fwd_a_dat,
  input  logic [BIT_W-1:0] fwd_b_dat,
  input  logic             alusrc_in,
  input  logic [3:0]       aluctrl_in,
  input  logic             muldiv_in,
  input  logic [2:0]       funct3_in,
  input  logic             jal_in,
  input  logic             jalr_in,
  input  logic             branch_in,
  input  logic [4:0]       rd_in,
  input  logic             memrd_in,
  input  logic             memwr_in,
  input  logic             mem2reg_in,
  input  logic             regwr_in,
  input  logic             stall_in,
  input  logic             flush_in,
  output logic [BIT_W-1:0] alu_result,
  output logic [BIT_W-1:0] mem_wdata,
  output logic [BIT_W-1:0] pc_plus_4,
  output logic [4:0]       rd_out,
  output logic             memrd_out,
  output logic             memwr_out,
  output logic             mem2reg_out,
  output logic             regwr_out,
  output logic             jump_out,
  output logic             valid_out,
  output logic             ex_busy,
  output logic             jump_noblock,
  output logic             branch_taken,
  output logic [BIT_W-1:0] pc_target_noblock
);
  localparam int SH_W  = $clog2(BIT_W);
  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_nx;

  logic [BIT_W-1:0] opa, opb, alu_a, alu_b, alu_out, pc4, jalr_sum;
  logic [SH_W-1:0]  shamt;
  logic             live, cond, busy, md_issue, div_sa, div_sb;

  // mul/div unit state
  logic [BIT_W-1:0]   md_a, md_b, quo, rem_q, dvs, md_result;
  logic [1:0]         md_op;
  logic               neg_q, neg_r, div_zero;
  logic [CNT_W-1:0]   cnt;
  logic               sa_mul, sb_mul;
  logic [2*BIT_W-1:0] prod;
  logic [BIT_W:0]     r_sh, r_diff;
  logic [BIT_W-1:0]   r_nx, q_nx, q_fix, r_fix, div_res;

  assign opa      = fwd_a_flag ? fwd_a_dat : rs1_dat_in;
  assign opb      = fwd_b_flag ? fwd_b_dat : rs2_dat_in;
  assign live     = valid_in & ~flush_in;
  assign pc4      = pc_in + BIT_W'(4);
  assign alu_a    = (jal_in | branch_in) ? pc_in : opa;
  assign alu_b    = alusrc_in ? imm : opb;
  assign shamt    = alu_b[SH_W-1:0];
  assign jalr_sum = opa + imm;

  assign pc_target_noblock = jalr_in ? {jalr_sum[BIT_W-1:1], 1'b0} : pc_in + imm;
  assign jump_noblock      = live & (jal_in | jalr_in);
  assign branch_taken      = live & branch_in & cond;

  // ALU: 0 and, 1 or, 2 add, 3 xor, 4 sll, 5 srl, 6 sub, 7 slt, 8 sltu, 9 sra, 10 pass B
  always_comb begin
    alu_out = '0;
    case (aluctrl_in)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd3:    alu_out = alu_a ^ alu_b;
      4'd4:    alu_out = alu_a << shamt;
      4'd5:    alu_out = alu_a >> shamt;
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = BIT_W'($signed(alu_a) < $signed(alu_b));
      4'd8:    alu_out = BIT_W'(alu_a < alu_b);
      4'd9:    alu_out = BIT_W'($signed(alu_a) >>> shamt);
      4'd10:   alu_out = alu_b;
      default: alu_out = '0;
    endcase
  end

  // Branch condition on forwarded operands
  always_comb begin
    cond = 1'b0;
    case (funct3_in)
      3'b000:  cond = (opa == opb);
      3'b001:  cond = (opa != opb);
      3'b100:  cond = ($signed(opa) <  $signed(opb));
      3'b101:  cond = ($signed(opa) >= $signed(opb));
      3'b110:  cond = (opa <  opb);
      3'b111:  cond = (opa >= opb);
      default: cond = 1'b0;
    endcase
  end

  // Multiplier: operands extended per op, low 2*BIT_W bits of product are exact
  assign sa_mul = (md_op != 2'b11) & md_a[BIT_W-1];
  assign sb_mul = (md_op == 2'b01) & md_b[BIT_W-1];
  assign prod   = {{BIT_W{sa_mul}}, md_a} * {{BIT_W{sb_mul}}, md_b};

  // Restoring divider step on magnitudes; sign fix folded into the final step
  assign r_sh    = {rem_q, quo[BIT_W-1]};
  assign r_diff  = r_sh - {1'b0, dvs};
  assign r_nx    = r_diff[BIT_W] ? r_sh[BIT_W-1:0] : r_diff[BIT_W-1:0];
  assign q_nx    = {quo[BIT_W-2:0], ~r_diff[BIT_W]};
  assign q_fix   = div_zero ? '1 : (neg_q ? -q_nx : q_nx);
  assign r_fix   = div_zero ? md_a : (neg_r ? -r_nx : r_nx);
  assign div_res = md_op[1] ? r_fix : q_fix;

  assign md_issue = (state == S_IDLE) & live & muldiv_in;
  assign div_sa   = ~funct3_in[0] & opa[BIT_W-1];
  assign div_sb   = ~funct3_in[0] & opb[BIT_W-1];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next state and busy handshake; flush returns to IDLE from any state
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      S_IDLE: if (md_issue) begin
        busy     = 1'b1;
        state_nx = funct3_in[2] ? S_DIV : S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (cnt == CNT_W'(MUL_CYCLES - 1)) state_nx = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (cnt == CNT_W'(DIV_CYCLES - 1)) state_nx = S_DONE;
      end
      S_DONE: if (!stall_in) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush_in) begin
      state_nx = S_IDLE;
      busy     = 1'b0;
    end
  end

  assign ex_busy = busy & ~rst;

  // Mul/div datapath: operand capture at issue, iteration, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      md_a <= '0; md_b <= '0; md_op <= '0; quo <= '0; rem_q <= '0; dvs <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; div_zero <= 1'b0; cnt <= '0; md_result <= '0;
    end else begin
      case (state)
        S_IDLE: if (md_issue) begin
          md_a     <= opa;
          md_b     <= opb;
          md_op    <= funct3_in[1:0];
          quo      <= div_sa ? -opa : opa;
          dvs      <= div_sb ? -opb : opb;
          rem_q    <= '0;
          neg_q    <= div_sa ^ div_sb;
          neg_r    <= div_sa;
          div_zero <= (opb == '0);
          cnt      <= '0;
        end
        S_MUL: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MUL_CYCLES - 1))
            md_result <= (md_op == 2'b00) ? prod[BIT_W-1:0] : prod[2*BIT_W-1:BIT_W];
        end
        S_DIV: begin
          cnt   <= cnt + CNT_W'(1);
          rem_q <= r_nx;
          quo   <= q_nx;
          if (cnt == CNT_W'(DIV_CYCLES - 1)) md_result <= div_res;
        end
        default: ;
      endcase
    end
  end

  // EX/MEM register: stall holds, flush/busy/invalid loads a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result <= '0; mem_wdata <= '0; pc_plus_4 <= '0; rd_out <= '0;
      memrd_out <= 1'b0; memwr_out <= 1'b0; mem2reg_out <= 1'b0;
      regwr_out <= 1'b0; jump_out <= 1'b0; valid_out <= 1'b0;
    end else if (!stall_in) begin
      if (flush_in | busy | ~valid_in) begin
        alu_result <= '0; mem_wdata <= '0; pc_plus_4 <= '0; rd_out <= '0;
        memrd_out <= 1'b0; memwr_out <= 1'b0; mem2reg_out <= 1'b0;
        regwr_out <= 1'b0; jump_out <= 1'b0; valid_out <= 1'b0;
      end else begin
        alu_result  <= (muldiv_in && state == S_DONE) ? md_result :
                       ((jal_in | jalr_in) ? pc4 : alu_out);
        mem_wdata   <= opb;
        pc_plus_4   <= pc4;
        rd_out      <= rd_in;
        memrd_out   <= memrd_in;
        memwr_out   <= memwr_in;
        mem2reg_out <= mem2reg_in;
        regwr_out   <= regwr_in;
        jump_out    <= jal_in | jalr_in;
        valid_out   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Randomized self-checking bench for ex_stage_muldiv against an arithmetic reference.
module tb_ex_stage_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [W-1:0] pc_in, rs1_dat_in, rs2_dat_in, imm, fwd_a_dat, fwd_b_dat;
  logic         fwd_a_flag, fwd_b_flag, alusrc_in, muldiv_in;
  logic [3:0]   aluctrl_in;
  logic [2:0]   funct3_in;
  logic         jal_in, jalr_in, branch_in;
  logic [4:0]   rd_in;
  logic         memrd_in, memwr_in, mem2reg_in, regwr_in, stall_in, flush_in;
  logic [W-1:0] alu_result, mem_wdata, pc_plus_4, pc_target_noblock;
  logic [4:0]   rd_out;
  logic         memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out, valid_out;
  logic         ex_busy, jump_noblock, branch_taken;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_stage_muldiv #(.BIT_W(W), .MUL_CYCLES(2), .DIV_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
    .rs1_dat_in(rs1_dat_in), .rs2_dat_in(rs2_dat_in), .imm(imm),
    .fwd_a_flag(fwd_a_flag), .fwd_b_flag(fwd_b_flag),
    .fwd_a_dat(fwd_a_dat), .fwd_b_dat(fwd_b_dat),
    .alusrc_in(alusrc_in), .aluctrl_in(aluctrl_in), .muldiv_in(muldiv_in),
    .funct3_in(funct3_in), .jal_in(jal_in), .jalr_in(jalr_in), .branch_in(branch_in),
    .rd_in(rd_in), .memrd_in(memrd_in), .memwr_in(memwr_in), .mem2reg_in(mem2reg_in),
    .regwr_in(regwr_in), .stall_in(stall_in), .flush_in(flush_in),
    .alu_result(alu_result), .mem_wdata(mem_wdata), .pc_plus_4(pc_plus_4),
    .rd_out(rd_out), .memrd_out(memrd_out), .memwr_out(memwr_out),
    .mem2reg_out(mem2reg_out), .regwr_out(regwr_out), .jump_out(jump_out),
    .valid_out(valid_out), .ex_busy(ex_busy), .jump_noblock(jump_noblock),
    .branch_taken(branch_taken), .pc_target_noblock(pc_target_noblock)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] flags();
    return W'({memrd_out, memwr_out, mem2reg_out, regwr_out, jump_out, valid_out});
  endfunction

  task automatic clear_in();
    valid_in = 0; pc_in = '0; rs1_dat_in = '0; rs2_dat_in = '0; imm = '0;
    fwd_a_flag = 0; fwd_b_flag = 0; fwd_a_dat = '0; fwd_b_dat = '0;
    alusrc_in = 0; aluctrl_in = 4'd2; muldiv_in = 0; funct3_in = '0;
    jal_in = 0; jalr_in = 0; branch_in = 0; rd_in = '0;
    memrd_in = 0; memwr_in = 0; mem2reg_in = 0; regwr_in = 0;
    stall_in = 0; flush_in = 0;
  endtask

  // Present operand values a/b through a random mix of register and forwarding paths
  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    fwd_a_flag = 1'($urandom_range(0, 1));
    fwd_b_flag = 1'($urandom_range(0, 1));
    rs1_dat_in = fwd_a_flag ? $urandom : a;
    fwd_a_dat  = fwd_a_flag ? a : $urandom;
    rs2_dat_in = fwd_b_flag ? $urandom : b;
    fwd_b_dat  = fwd_b_flag ? b : $urandom;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned sh = y[4:0];
    int sx = x;
    int sy = y;
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x ^ y;
      4'd4:  return x << sh;
      4'd5:  return x >> sh;
      4'd6:  return x - y;
      4'd7:  return (sx < sy) ? 1 : 0;
      4'd8:  return (x < y) ? 1 : 0;
      4'd9:  return sx >>> sh;
      4'd10: return y;
      default: return '0;
    endcase
  endfunction

  function automatic logic cond_ref(input logic [2:0] f3, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx = x;
    int sy = y;
    case (f3)
      3'b000: return x == y;
      3'b001: return x != y;
      3'b100: return sx < sy;
      3'b101: return sx >= sy;
      3'b110: return x < y;
      3'b111: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] md_ref(input logic [2:0] f3, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint uy = longint'({32'b0, y});
    longint p;
    logic [63:0] up;
    int six = x;
    int siy = y;
    logic ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        return six / siy;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return '0;
        return six % siy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one M-extension op and check busy length and the EX/MEM result
  task automatic run_md(input logic [2:0] f3, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int busy_n = 0;
    logic [4:0] rd;
    logic [W-1:0] pc;
    clear_in();
    rd = 5'($urandom_range(1, 31));
    pc = {$urandom, 2'b00};
    valid_in = 1; muldiv_in = 1; funct3_in = f3; regwr_in = 1; rd_in = rd; pc_in = pc;
    aluctrl_in = 4'($urandom_range(0, 10));
    set_ops(x, y);
    #1;
    while (ex_busy && busy_n < 200) begin
      busy_n++;
      tick();
    end
    check_eq({tag, " busy cycles"}, W'(busy_n), f3[2] ? 32'd33 : 32'd3);
    check_eq({tag, " bubble while busy"}, W'(valid_out), '0);
    tick();
    check_eq({tag, " result"}, alu_result, md_ref(f3, x, y));
    check_eq({tag, " flags"}, flags(), 32'b000101);
    check_eq({tag, " rd"}, W'(rd_out), W'(rd));
    check_eq({tag, " wdata"}, mem_wdata, y);
    check_eq({tag, " pc4"}, pc_plus_4, pc + 4);
    clear_in();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b, im, pc, expv, bv;
    logic [3:0] op;
    logic [2:0] f3;
    logic [5:0] fl;
    logic [4:0] rd;
    int busy_n;
    int seen_valid;

    // ---- reset with a live muldiv instruction presented ----
    clear_in();
    rst = 1; valid_in = 1; muldiv_in = 1; aluctrl_in = 4'd2; regwr_in = 1; rd_in = 5'd4;
    set_ops(32'd11, 32'd13);
    repeat (3) begin
      tick();
      check_eq("reset alu_result", alu_result, '0);
      check_eq("reset wdata", mem_wdata, '0);
      check_eq("reset pc4", pc_plus_4, '0);
      check_eq("reset flags", flags() | W'(rd_out) << 8, '0);
      check_eq("reset busy", W'(ex_busy), '0);
    end

    // ---- first instruction after reset: ADD 5+7 ----
    rst = 0; muldiv_in = 0; pc_in = 32'h100; rd_in = 5'd3;
    set_ops(32'd5, 32'd7);
    tick();
    check_eq("add result", alu_result, 32'd12);
    check_eq("add flags", flags(), 32'b000101);
    check_eq("add pc4", pc_plus_4, 32'h104);
    check_eq("add rd", W'(rd_out), 32'd3);
    clear_in();
    tick();
    check_eq("idle bubble", W'(valid_out), '0);

    // ---- randomized ALU ops ----
    for (int i = 0; i < 40; i++) begin
      clear_in();
      a = pick_operand(); b = pick_operand(); im = $urandom;
      op = 4'($urandom_range(0, 10));
      fl = 6'($urandom_range(0, 15)) << 2;
      rd = 5'($urandom_range(0, 31));
      pc = {$urandom, 2'b00};
      valid_in = 1; aluctrl_in = op; alusrc_in = 1'($urandom_range(0, 1)); imm = im;
      memrd_in = fl[5]; memwr_in = fl[4]; mem2reg_in = fl[3]; regwr_in = fl[2];
      rd_in = rd; pc_in = pc;
      set_ops(a, b);
      bv = alusrc_in ? im : b;
      tick();
      check_eq("alu result", alu_result, alu_ref(op, a, bv));
      check_eq("alu wdata", mem_wdata, b);
      check_eq("alu flags", flags(), W'(fl | 6'b000001));
      check_eq("alu rd", W'(rd_out), W'(rd));
    end

    // ---- stall holds EX/MEM for a normal instruction ----
    clear_in();
    valid_in = 1; aluctrl_in = 4'd6; regwr_in = 1; rd_in = 5'd7;
    set_ops(32'd100, 32'd58);
    tick();
    check_eq("sub result", alu_result, 32'd42);
    stall_in = 1; aluctrl_in = 4'd2; rd_in = 5'd9;
    set_ops(32'd1, 32'd2);
    repeat (2) tick();
    check_eq("stall hold result", alu_result, 32'd42);
    check_eq("stall hold rd", W'(rd_out), 32'd7);
    stall_in = 0;
    tick();
    check_eq("after stall result", alu_result, 32'd3);

    // ---- directed M-extension cases ----
    run_md(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH min*min");
    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU max*max");
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2, "REM -7%2");
    run_md(3'd5, 32'd1234, 32'd0, "DIVU by 0");
    run_md(3'd6, 32'hDEAD_BEEF, 32'd0, "REM by 0");
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV overflow");
    run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM overflow");
    run_md(3'd4, 32'hFFFF_FFF9, 32'd0, "DIV neg by 0");

    // ---- randomized M-extension ops ----
    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      run_md(f3, pick_operand(), pick_operand(), "md rand");
    end

    // ---- branches ----
    clear_in();
    valid_in = 1; branch_in = 1; funct3_in = 3'b100; pc_in = 32'h400; imm = 32'h20;
    set_ops(32'hFFFF_FFFF, 32'd1);
    #1;
    check_eq("BLT taken", W'(branch_taken), 32'd1);
    check_eq("BLT target", pc_target_noblock, 32'h420);
    funct3_in = 3'b110;
    #1;
    check_eq("BLTU not taken", W'(branch_taken), '0);
    funct3_in = 3'b000; flush_in = 1;
    set_ops(32'd5, 32'd5);
    #1;
    check_eq("BEQ flushed", W'(branch_taken), '0);
    tick();
    check_eq("flush bubble", W'(valid_out), '0);
    for (int i = 0; i < 24; i++) begin
      clear_in();
      a = pick_operand();
      b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      f3 = 3'($urandom_range(0, 7));
      pc = {$urandom, 2'b00}; im = $urandom;
      valid_in = 1; branch_in = 1; funct3_in = f3; pc_in = pc; imm = im;
      set_ops(a, b);
      #1;
      check_eq("branch cond", W'(branch_taken), W'(cond_ref(f3, a, b)));
      check_eq("branch target", pc_target_noblock, pc + im);
      check_eq("branch no jump", W'(jump_noblock), '0);
      tick();
    end

    // ---- jumps ----
    clear_in();
    valid_in = 1; jalr_in = 1; pc_in = 32'h200; imm = 32'd4; regwr_in = 1; rd_in = 5'd1;
    set_ops(32'h1003, 32'h55);
    #1;
    check_eq("JALR target", pc_target_noblock, 32'h1006);
    check_eq("JALR redirect", W'(jump_noblock), 32'd1);
    tick();
    check_eq("JALR link", alu_result, 32'h204);
    check_eq("JALR flags", flags(), 32'b000111);
    for (int i = 0; i < 8; i++) begin
      clear_in();
      pc = {$urandom, 2'b00}; im = $urandom; a = $urandom;
      valid_in = 1; regwr_in = 1; pc_in = pc; imm = im;
      if (i[0]) jal_in = 1; else jalr_in = 1;
      set_ops(a, $urandom);
      expv = i[0] ? pc + im : ((a + im) & ~32'd1);
      #1;
      check_eq("jump target", pc_target_noblock, expv);
      check_eq("jump redirect", W'(jump_noblock), 32'd1);
      tick();
      check_eq("jump link", alu_result, pc + 4);
      check_eq("jump_out", W'(jump_out), 32'd1);
    end

    // ---- flush in the middle of a divide ----
    clear_in();
    valid_in = 1; muldiv_in = 1; funct3_in = 3'b100; regwr_in = 1; rd_in = 5'd5;
    set_ops(32'hFFFF_FF9C, 32'd7);
    #1;
    check_eq("flushdiv issue busy", W'(ex_busy), 32'd1);
    repeat (10) tick();
    check_eq("flushdiv mid busy", W'(ex_busy), 32'd1);
    flush_in = 1;
    #1;
    check_eq("flushdiv busy drop", W'(ex_busy), '0);
    tick();
    clear_in();
    #1;
    check_eq("flushdiv idle", W'(ex_busy), '0);
    seen_valid = 0;
    repeat (40) begin
      tick();
      if (valid_out || ex_busy) seen_valid++;
    end
    check_eq("flushdiv no result", W'(seen_valid), '0);
    run_md(3'd4, 32'hFFFF_FF9C, 32'd7, "DIV after flush");

    // ---- divide with stall during iteration and while done ----
    clear_in();
    valid_in = 1; muldiv_in = 1; funct3_in = 3'b100; regwr_in = 1; rd_in = 5'd12;
    set_ops(32'd1000, 32'hFFFF_FFFD);
    #1;
    busy_n = 0;
    while (ex_busy && busy_n < 200) begin
      busy_n++;
      stall_in = (busy_n >= 5 && busy_n < 9);
      tick();
    end
    check_eq("stalldiv busy cycles", W'(busy_n), 32'd33);
    stall_in = 1;
    repeat (4) begin
      tick();
      check_eq("stalldiv done busy", W'(ex_busy), '0);
      check_eq("stalldiv hold valid", W'(valid_out), '0);
      check_eq("stalldiv hold result", alu_result, '0);
    end
    stall_in = 0;
    tick();
    check_eq("stalldiv result", alu_result, md_ref(3'd4, 32'd1000, 32'hFFFF_FFFD));
    check_eq("stalldiv valid", W'(valid_out), 32'd1);
    check_eq("stalldiv rd", W'(rd_out), 32'd12);
    clear_in();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
